i2s_xmit: RTL and testbench
===========================

Name: i2s_xmit

Overview:
- I2S transmitter: the DAC-side counterpart of the ADC receive path. It serialises stereo 24-bit samples from the mixer core onto DATA_OUT.
- It is bus master: generates BCK and LRC from CLK, with CLK = 256*fs (12.288 MHz at fs = 48 kHz).
- Frame is 64 BCK: a 32-bit left slot (LRC=0) then a 32-bit right slot (LRC=1). Data is MSB-first with the standard I2S one-BCK delay after each LRC edge.
- A one-entry holding register with a valid/ready handshake decouples the mixer from frame timing.

Parameters:
- CLK_DIV, 4, CLK cycles per BCK period; must be even and >=2. Default gives BCK = 64*fs.
- WORD_W, 24, sample width in bits; must be <= SLOT_W-1.
- SLOT_W, 32, BCK cycles per channel slot.

Ports:
- CLK  in  1  system clock (256*fs); all logic is on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- left_in  in  WORD_W  left sample, two's complement.
- right_in  in  WORD_W  right sample, two's complement.
- in_valid  in  1  left_in/right_in hold a valid stereo pair.
- in_ready  out  1  holding register is empty; a pair is accepted when in_valid & in_ready.
- frame_start  out  1  one-CLK pulse when a new left slot begins.
- underrun  out  1  one-CLK pulse when a frame starts with the holding register empty.
- BCK  out  1  bit clock, registered.
- LRC  out  1  word select, registered; 0 = left, 1 = right.
- DATA_OUT  out  1  serial data, registered.

Behaviour:
- Reset values:
  - Outputs: BCK=0, LRC=0, DATA_OUT=0, in_ready=1, frame_start=0, underrun=0.
  - Internal: bit_cnt=2*SLOT_W-1, divider=0, holding register empty, shift registers zero.
- Divider and BCK:
  - H = CLK_DIV/2. The divider counts 0..H-1; at H-1 it wraps and BCK toggles.
  - A 1->0 BCK toggle is a "fall event". All LRC/DATA_OUT updates occur in the same CLK edge as the BCK falling toggle, so the receiver sees stable data at BCK rising edges.
- bit_cnt:
  - 0..2*SLOT_W-1, advanced on every fall event, wraps 63 -> 0.
  - After reset, the first fall event occurs at CLK cycle 2H and sets bit_cnt=0.
- LRC = bit_cnt[log2(SLOT_W)] (0 for positions 0..31, 1 for 32..63), updated on the fall event.
- Slot position p = bit_cnt mod SLOT_W. DATA_OUT for each p:
  - p=0: 0 (I2S delay bit).
  - p=1..WORD_W: sample bit WORD_W-p, MSB first.
  - p=WORD_W+1..SLOT_W-1: 0.
- Frame start (fall event with bit_cnt becoming 0):
  - Holding register full: copy the held left/right pair into the left and right shift registers, mark the holding register empty, pulse frame_start.
  - Holding register empty: load zeros into both shift registers, pulse frame_start and underrun together.
- Handshake:
  - in_ready = !full, registered. A pair is captured on a CLK edge with in_valid & in_ready; full=1 from the next cycle.
  - Acceptance in the same cycle as a frame-start load: the load sees the pre-edge (empty) state and outputs zeros with underrun; the new pair stays held for the next frame.
  - in_valid while full: ignored; inputs are not sampled.
- Latency: an accepted pair begins (MSB on DATA_OUT) one BCK period after the next frame start, and is fully sent within 2 frames (<= 512 CLK at default).
- Right word: right samples are loaded at the same frame start as left; they shift out during positions 33..56.
- Reset mid-frame: all state returns to reset values immediately, asynchronously. Any held or partially sent sample is discarded. No partial-frame resume.

Decomposition:
- Package i2s_pkg holds:
  - SLOT_W and WORD_W defaults.
  - LEFT_CHANNEL=1'b0 and RIGHT_CHANNEL=1'b1.
  - The frame-position constants: delay bit, first data bit, last data bit. These are shared with the receive side.
- Sub-module i2s_bclk_gen: CLK_DIV divider producing registered BCK plus a one-CLK fall_evt strobe. The top module contains bit_cnt, the holding register, the shift registers and the handshake.

Test Plan:
- Reset check (CLK_DIV=4): assert RST mid-run. BCK, LRC and DATA_OUT go to 0 and in_ready to 1 without waiting for a CLK edge. After release, the first BCK rise is at CLK 2 and the first frame_start at CLK 4.
- Single frame: left=24'hA5F00F, right=24'h800001 accepted before the first frame start.
  - Sample DATA_OUT at BCK rises. Left slot: positions 1..24 give A5F00F MSB-first; positions 0 and 25..31 are 0.
  - Right slot: same layout gives 800001.
  - LRC toggles every 32 BCK.
- Underrun: no in_valid for 3 frames. DATA_OUT is all-zero, with underrun pulsing once per frame start (3 pulses, 256 CLK apart).
- Backpressure: hold in_valid high with a new pair each time it is accepted. in_ready drops for exactly one frame per pair, with no underrun and no dropped or duplicated pairs over 8 frames (pairs 1..8 appear in order).
- Simultaneous accept/load: assert in_valid exactly on the frame-start CLK edge with the holding register empty. That frame outputs zeros with underrun=1; the next frame carries the pair.
- CLK_DIV=8 regression: the BCK period is 8 CLK, a frame is 512 CLK, and serial data is correct with left=24'h7FFFFF, right=24'hFFFFFF.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: constants and helpers shared by the I2S transmit and receive paths.
//   DEF_SLOT_W / DEF_WORD_W  : default slot length (BCK cycles) and sample width
//   LEFT_CHANNEL / RIGHT_CHANNEL : LRC level for each channel
//   POS_DELAY_BIT / POS_FIRST_DATA / POS_LAST_DATA : positions within a slot
//   slot_phase()             : classifies a slot position as delay, data or pad
package i2s_pkg;

    localparam int DEF_SLOT_W = 32;
    localparam int DEF_WORD_W = 24;

    localparam logic LEFT_CHANNEL  = 1'b0;
    localparam logic RIGHT_CHANNEL = 1'b1;

    // Standard I2S: one delay bit after each LRC edge, then the word MSB-first.
    localparam int POS_DELAY_BIT  = 0;
    localparam int POS_FIRST_DATA = 1;
    localparam int POS_LAST_DATA  = POS_FIRST_DATA + DEF_WORD_W - 1;

    typedef enum logic [1:0] {
        PH_DELAY,
        PH_DATA,
        PH_PAD
    } slot_phase_t;

    // last_data is passed in so non-default word widths share the same rule.
    function automatic slot_phase_t slot_phase(input int pos, input int last_data);
        if (pos == POS_DELAY_BIT) begin
            return PH_DELAY;
        end
        if (pos >= POS_FIRST_DATA && pos <= last_data) begin
            return PH_DATA;
        end
        return PH_PAD;
    endfunction

endpackage

// File: rtl/i2s_xmit_if.sv
// i2s_xmit_if: sample handshake plus serial bus of the I2S transmitter.
//   left_in/right_in/in_valid : stereo pair offered by the mixer
//   in_ready                  : transmitter holding register is empty
//   frame_start/underrun      : per-frame status pulses
//   BCK/LRC/DATA_OUT          : I2S serial bus towards the DAC
// master = mixer side, slave = transmitter side.
interface i2s_xmit_if
    import i2s_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic signed [WORD_W-1:0] left_in;
    logic signed [WORD_W-1:0] right_in;
    logic                     in_valid;
    logic                     in_ready;
    logic                     frame_start;
    logic                     underrun;
    logic                     BCK;
    logic                     LRC;
    logic                     DATA_OUT;

    modport master (
        output left_in, right_in, in_valid,
        input  in_ready, frame_start, underrun, BCK, LRC, DATA_OUT
    );

    modport slave (
        input  left_in, right_in, in_valid,
        output in_ready, frame_start, underrun, BCK, LRC, DATA_OUT
    );
endinterface

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides CLK by CLK_DIV into the registered bit clock.
//   CLK, RST  : system clock, asynchronous active-high reset
//   BCK       : registered bit clock, 0 after reset
//   fall_evt  : high for the one CLK cycle whose closing edge drives BCK 1->0
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    output logic BCK,
    output logic fall_evt
);
    localparam int H     = CLK_DIV / 2;
    localparam int DIV_W = (H > 1) ? $clog2(H) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(H - 1);

    logic [DIV_W-1:0] div;
    logic             wrap;

    assign wrap     = (div == DIV_LAST);
    // Strobe is decoded from current state so the consumer updates on the
    // very edge that lowers BCK.
    assign fall_evt = wrap && BCK;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div <= '0;
            BCK <= 1'b0;
        end else if (wrap) begin
            div <= '0;
            BCK <= ~BCK;
        end else begin
            div <= div + 1'b1;
        end
    end
endmodule

// File: rtl/i2s_xmit.sv
// i2s_xmit: I2S master transmitter, stereo samples to DATA_OUT.
//   CLK, RST : system clock (256*fs), asynchronous active-high reset
//   bus      : slave side of i2s_xmit_if (sample handshake, status pulses,
//              BCK/LRC/DATA_OUT serial outputs, all registered)
// A one-entry holding register decouples the mixer from frame timing; it is
// transferred into the shift registers at every frame start.
module i2s_xmit
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = DEF_WORD_W,
    parameter int SLOT_W  = DEF_SLOT_W
) (
    input  logic      CLK,
    input  logic      RST,
    i2s_xmit_if.slave bus
);
    localparam int POS_W     = $clog2(SLOT_W);
    localparam int CNT_W     = POS_W + 1;
    localparam int LAST_DATA = POS_FIRST_DATA + WORD_W - 1;
    // SLOT_W is a power of two, so all-ones is 2*SLOT_W-1.
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    logic                     bck;
    logic                     fall_evt;
    logic [CNT_W-1:0]         bit_cnt;
    logic [CNT_W-1:0]         bit_cnt_nxt;
    logic [POS_W-1:0]         pos_nxt;
    logic                     chan_nxt;
    slot_phase_t              phase_nxt;
    logic                     frame_evt;
    logic                     accept;
    logic                     full;
    logic signed [WORD_W-1:0] hold_l;
    logic signed [WORD_W-1:0] hold_r;
    logic signed [WORD_W-1:0] left_sr;
    logic signed [WORD_W-1:0] right_sr;
    logic                     lrc;
    logic                     data_out;
    logic                     frame_start;
    logic                     underrun;

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .CLK      (CLK),
        .RST      (RST),
        .BCK      (bck),
        .fall_evt (fall_evt)
    );

    // Counter wraps naturally at 2*SLOT_W.
    assign bit_cnt_nxt = bit_cnt + 1'b1;
    assign pos_nxt     = bit_cnt_nxt[POS_W-1:0];
    assign chan_nxt    = bit_cnt_nxt[POS_W];
    assign phase_nxt   = slot_phase(32'(pos_nxt), LAST_DATA);
    assign frame_evt   = fall_evt && (bit_cnt == CNT_LAST);
    assign accept      = bus.in_valid && !full;

    // full is a flop, so in_ready is a registered output.
    assign bus.in_ready    = !full;
    assign bus.BCK         = bck;
    assign bus.LRC         = lrc;
    assign bus.DATA_OUT    = data_out;
    assign bus.frame_start = frame_start;
    assign bus.underrun    = underrun;

    // Serialiser: everything moves on the BCK falling edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt     <= CNT_LAST;
            lrc         <= LEFT_CHANNEL;
            data_out    <= 1'b0;
            left_sr     <= '0;
            right_sr    <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= frame_evt;
            underrun    <= frame_evt && !full;
            if (fall_evt) begin
                bit_cnt  <= bit_cnt_nxt;
                lrc      <= chan_nxt;
                data_out <= 1'b0;
                if (frame_evt) begin
                    // Load sees the pre-edge state: an accept on this same
                    // edge is held for the following frame.
                    left_sr  <= full ? hold_l : '0;
                    right_sr <= full ? hold_r : '0;
                end else if (phase_nxt == PH_DATA) begin
                    if (chan_nxt == LEFT_CHANNEL) begin
                        data_out <= left_sr[WORD_W-1];
                        left_sr  <= {left_sr[WORD_W-2:0], 1'b0};
                    end else if (chan_nxt == RIGHT_CHANNEL) begin
                        data_out <= right_sr[WORD_W-1];
                        right_sr <= {right_sr[WORD_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    // Holding register occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full <= 1'b0;
        end else if (frame_evt && full) begin
            full <= 1'b0;
        end else if (accept) begin
            full <= 1'b1;
        end
    end

    // Holding register data; only meaningful while full is set.
    always_ff @(posedge CLK) begin
        if (accept) begin
            hold_l <= bus.left_in;
            hold_r <= bus.right_in;
        end
    end
endmodule

// File: tb/tb_i2s_xmit.sv
// tb_i2s_xmit: directed bench for i2s_xmit at CLK_DIV=4 and CLK_DIV=8.
// Serial frames are captured at BCK rising edges and compared with
// hand-computed slot words (position 0 is the MSB of each 32-bit slot).
module tb_i2s_xmit;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    i2s_xmit_if bus4 ();
    i2s_xmit_if bus8 ();

    i2s_xmit #(.CLK_DIV(4)) dut4 (.CLK(CLK), .RST(RST), .bus(bus4));
    i2s_xmit #(.CLK_DIV(8)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8));

    logic [23:0] drv_left  = '0;
    logic [23:0] drv_right = '0;
    logic        drv_valid = 1'b0;
    logic        sel       = 1'b0;   // 0 = observe/drive dut4, 1 = dut8

    assign bus4.left_in  = drv_left;
    assign bus4.right_in = drv_right;
    assign bus4.in_valid = drv_valid & ~sel;
    assign bus8.left_in  = drv_left;
    assign bus8.right_in = drv_right;
    assign bus8.in_valid = drv_valid & sel;

    logic mon_bck, mon_lrc, mon_data, mon_ready, mon_fs, mon_und;
    assign mon_bck   = sel ? bus8.BCK         : bus4.BCK;
    assign mon_lrc   = sel ? bus8.LRC         : bus4.LRC;
    assign mon_data  = sel ? bus8.DATA_OUT    : bus4.DATA_OUT;
    assign mon_ready = sel ? bus8.in_ready    : bus4.in_ready;
    assign mon_fs    = sel ? bus8.frame_start : bus4.frame_start;
    assign mon_und   = sel ? bus8.underrun    : bus4.underrun;

    int unsigned cyc     = 0;
    int unsigned und_cnt = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) if (mon_und) und_cnt <= und_cnt + 1;

    int          total       = 0;
    int          bad         = 0;
    int          cur_div     = 4;
    int unsigned last_fs_cyc = 0;
    int unsigned acc_cyc [1:8];

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;
    vec_t vecs [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] slot_word(input logic [23:0] w);
        return {1'b0, w, 7'b0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_fs(output logic und);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!mon_fs && n < 3000);
        if (!mon_fs) begin
            total++;
            bad++;
            $display("FAIL wait_frame_start: no frame_start within %0d cycles", n);
        end
        und = mon_und;
    endtask

    task automatic capture_bits(output logic [63:0] data, output logic [63:0] lrc, output int span);
        logic        prev;
        int          k;
        int          n;
        int unsigned first;
        prev  = mon_bck;
        k     = 0;
        n     = 0;
        first = 0;
        data  = '0;
        lrc   = '0;
        span  = 0;
        while (k < 64 && n < 2000) begin
            @(negedge CLK);
            n++;
            if (mon_bck && !prev) begin
                data[63-k] = mon_data;
                lrc[63-k]  = mon_lrc;
                if (k == 0)  first = cyc;
                if (k == 63) span = int'(cyc - first);
                k++;
            end
            prev = mon_bck;
        end
        if (k < 64) begin
            total++;
            bad++;
            $display("FAIL capture_bits: only %0d of 64 BCK rises seen", k);
        end
    endtask

    task automatic do_frame(input string name, input logic [31:0] exp_l, input logic [31:0] exp_r,
                            input logic exp_und);
        logic        u;
        logic [63:0] d;
        logic [63:0] l;
        int          span;
        wait_fs(u);
        last_fs_cyc = cyc;
        capture_bits(d, l, span);
        check({name, "_underrun"}, 64'(u), 64'(exp_und));
        check({name, "_left"},     64'(d[63:32]), 64'(exp_l));
        check({name, "_right"},    64'(d[31:0]),  64'(exp_r));
        check({name, "_lrc"},      l, {32'h0, 32'hFFFF_FFFF});
        check({name, "_bck_span"}, 64'(span), 64'(63 * cur_div));
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        int n;
        n = 0;
        @(negedge CLK);
        drv_left  = l;
        drv_right = r;
        drv_valid = 1'b1;
        while (!mon_ready && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (!mon_ready) begin
            total++;
            bad++;
            $display("FAIL send_pair: in_ready=%0b after %0d cycles, required 1", mon_ready, n);
        end
        @(posedge CLK);
        @(negedge CLK);
        drv_valid = 1'b0;
    endtask

    // Releases RST at a falling CLK edge and checks the first BCK/frame timing.
    task automatic reset_release_check(input string name);
        logic b [1:4];
        logic f [1:4];
        logic u4;
        @(negedge CLK);
        RST = 1'b0;
        u4  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK);
            #1;
            b[k] = mon_bck;
            f[k] = mon_fs;
            if (k == 4) u4 = mon_und;
        end
        check({name, "_bck_clk1"}, 64'(b[1]), 64'd0);
        check({name, "_bck_clk2"}, 64'(b[2]), 64'd1);
        check({name, "_bck_clk4"}, 64'(b[4]), 64'd0);
        check({name, "_fs_clk3"},  64'(f[3]), 64'd0);
        check({name, "_fs_clk4"},  64'(f[4]), 64'd1);
        check({name, "_und_clk4"}, 64'(u4),   64'd1);
    endtask

    initial begin
        logic        u;
        logic [63:0] d;
        logic [63:0] l;
        int          span;
        int unsigned snap;
        int unsigned fs_at [3];
        int          n;

        vecs[0] = '{24'hA5F00F, 24'h800001, 32'h52F8_0780, 32'h4000_0080};
        vecs[1] = '{24'h123456, 24'hFEDCBA, 32'h091A_2B00, 32'h7F6E_5D00};
        vecs[2] = '{24'h000001, 24'h7FFFFF, 32'h0000_0080, 32'h3FFF_FF80};
        vecs[3] = '{24'h800000, 24'h000001, 32'h4000_0000, 32'h0000_0080};

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_bck",   64'(mon_bck),   64'd0);
        check("rst_lrc",   64'(mon_lrc),   64'd0);
        check("rst_data",  64'(mon_data),  64'd0);
        check("rst_ready", 64'(mon_ready), 64'd1);
        check("rst_fs",    64'(mon_fs),    64'd0);
        check("rst_und",   64'(mon_und),   64'd0);
        reset_release_check("init");

        // Table-driven single frames
        for (int i = 0; i < 4; i++) begin
            wait_fs(u);
            send_pair(vecs[i].left, vecs[i].right);
            do_frame($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r, 1'b0);
        end

        // Underrun: three empty frames
        snap = und_cnt;
        for (int f = 0; f < 3; f++) begin
            do_frame($sformatf("und%0d", f), 32'h0, 32'h0, 1'b1);
            fs_at[f] = last_fs_cyc;
        end
        check("und_period_a", 64'(fs_at[1] - fs_at[0]), 64'd256);
        check("und_period_b", 64'(fs_at[2] - fs_at[1]), 64'd256);
        check("und_pulses",   64'(und_cnt - snap),      64'd3);

        // Backpressure: in_valid held, pairs 1..8 in order
        wait_fs(u);
        @(negedge CLK);
        snap = und_cnt;
        fork
            begin : feeder
                int w;
                for (int i = 1; i <= 8; i++) begin
                    drv_left  = 24'(i);
                    drv_right = 24'h800000 | 24'(i);
                    drv_valid = 1'b1;
                    w = 0;
                    while (!mon_ready && w < 3000) begin
                        @(negedge CLK);
                        w++;
                    end
                    if (!mon_ready) begin
                        total++;
                        bad++;
                        $display("FAIL bp_accept%0d: in_ready=0 after %0d cycles, required 1", i, w);
                    end
                    @(posedge CLK);
                    @(negedge CLK);
                    acc_cyc[i] = cyc;
                end
                drv_valid = 1'b0;
            end
            begin : collector
                for (int k = 1; k <= 8; k++) begin
                    do_frame($sformatf("bp%0d", k), slot_word(24'(k)),
                             slot_word(24'h800000 | 24'(k)), 1'b0);
                end
            end
        join
        for (int i = 3; i <= 8; i++) begin
            check($sformatf("bp_interval%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd256);
        end
        check("bp_no_underrun", 64'(und_cnt - snap), 64'd0);

        // Accept on the frame-start edge with the holding register empty
        do_frame("sim_pre", 32'h0, 32'h0, 1'b1);
        repeat (cur_div / 2 - 1) @(negedge CLK);
        drv_left  = 24'h13579B;
        drv_right = 24'h2468AC;
        drv_valid = 1'b1;
        check("sim_ready_before", 64'(mon_ready), 64'd1);
        @(negedge CLK);
        drv_valid = 1'b0;
        check("sim_fs",          64'(mon_fs),    64'd1);
        check("sim_und",         64'(mon_und),   64'd1);
        check("sim_ready_after", 64'(mon_ready), 64'd0);
        capture_bits(d, l, span);
        check("sim_zero_frame", d, 64'h0);
        do_frame("sim_next", 32'h09AB_CD80, 32'h1234_5600, 1'b0);

        // Asynchronous reset in the middle of a right-slot data bit
        wait_fs(u);
        send_pair(24'hFFFFFF, 24'hFFFFFF);
        wait_fs(u);
        send_pair(24'hFFFFFF, 24'hFFFFFF);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(mon_bck && mon_data && mon_lrc) && n < 1000);
        check("mid_active", 64'({mon_bck, mon_data, mon_lrc, mon_ready}), 64'b1110);
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_bck",   64'(mon_bck),   64'd0);
        check("mid_rst_lrc",   64'(mon_lrc),   64'd0);
        check("mid_rst_data",  64'(mon_data),  64'd0);
        check("mid_rst_ready", 64'(mon_ready), 64'd1);
        reset_release_check("mid");
        do_frame("post_rst", 32'h0, 32'h0, 1'b1);

        // CLK_DIV=8 instance
        @(negedge CLK);
        sel     = 1'b1;
        cur_div = 8;
        wait_fs(u);
        send_pair(24'h7FFFFF, 24'hFFFFFF);
        do_frame("div8", 32'h3FFF_FF80, 32'h7FFF_FF80, 1'b0);
        wait_fs(u);
        check("div8_frame_period", 64'(cyc - last_fs_cyc), 64'd512);
        check("div8_next_und",     64'(u),                 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
